// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address-field helpers for the L1 data cache.
// Address layout: [31:9] tag, [8:5] index, [4:2] word, [1:0] byte (ignored).
package cache_pkg;

  localparam int ADDR_W     = 32;
  localparam int SETS       = 16;
  localparam int IDX_W      = $clog2(SETS);
  localparam int WORDS      = 8;
  localparam int WORD_SEL_W = $clog2(WORDS);
  localparam int OFFSET_W   = WORD_SEL_W + 2;
  localparam int LINE_BITS  = 256;
  localparam int TAG_W      = ADDR_W - OFFSET_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    FILL      = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: IDX_W];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WORD_SEL_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage for the data cache: per-set valid/dirty/tag/data with async read.
// Valid and dirty clear asynchronously on reset; tag and data are left as-is.
module dcache_sram
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic                 fill_we,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic                 word_we,
  input  logic [WORDS-1:0]     word_mask,
  input  logic [LINE_BITS-1:0] wr_data
);

  logic [SETS-1:0]      valid;
  logic [SETS-1:0]      dirty;
  logic [TAG_W-1:0]     tags  [SETS];
  logic [LINE_BITS-1:0] lines [SETS];

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_line  = lines[rd_idx];

  // A fill replaces the whole line; a store hit touches only the masked word.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tags[wr_idx]  <= fill_tag;
      lines[wr_idx] <= wr_data;
    end else if (word_we) begin
      for (int w = 0; w < WORDS; w++) begin
        if (word_mask[w]) begin
          lines[wr_idx][w*32 +: 32] <= wr_data[w*32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= 1'b0;
    end else if (word_we) begin
      dirty[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits finish in the request cycle; misses stall the pipeline through WRITEBACK/ALLOCATE/FILL.
module dcache_controller
  import cache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  state_t               state;
  state_t               next_state;
  logic                 req;
  logic                 hit;
  logic [TAG_W-1:0]     miss_tag;
  logic [IDX_W-1:0]     miss_idx;
  logic [LINE_BITS-1:0] fill_line;

  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 fill_we;
  logic                 word_we;
  logic [WORDS-1:0]     word_mask;
  logic [LINE_BITS-1:0] wr_data;
  logic [7:0]           word_lsb;

  assign req = cpu_MemRead_i | cpu_MemWrite_i;

  // Outside IDLE only the latched miss index may address the array.
  assign rd_idx = (state == IDLE) ? addr_idx(cpu_addr_i) : miss_idx;
  assign hit    = (state == IDLE) && rd_valid && (rd_tag == addr_tag(cpu_addr_i));

  assign fill_we   = (state == FILL);
  assign word_we   = (state == IDLE) && req && hit && cpu_MemWrite_i;
  assign word_mask = WORDS'(1) << addr_word(cpu_addr_i);
  assign wr_data   = fill_we ? fill_line : {WORDS{cpu_data_i}};
  assign word_lsb  = {addr_word(cpu_addr_i), 5'b0};

  dcache_sram u_sram (
    .clk       (clk_i),
    .rst       (rst_i),
    .rd_idx    (rd_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_idx    (rd_idx),
    .fill_we   (fill_we),
    .fill_tag  (miss_tag),
    .word_we   (word_we),
    .word_mask (word_mask),
    .wr_data   (wr_data)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          next_state = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (mem_ack_i) next_state = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) next_state = FILL;
      FILL:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_tag  <= '0;
      miss_idx  <= '0;
      fill_line <= '0;
    end else begin
      if (state == IDLE && req && !hit) begin
        miss_tag <= addr_tag(cpu_addr_i);
        miss_idx <= addr_idx(cpu_addr_i);
      end
      if (state == ALLOCATE && mem_ack_i) begin
        fill_line <= mem_data_i;
      end
    end
  end

  // Stall is gated by reset so a held request cannot re-raise it while reset is asserted.
  assign cpu_stall_o  = !rst_i && ((state != IDLE) || (req && !hit));
  assign cpu_data_o   = (req && hit) ? rd_line[word_lsb +: 32] : 32'h0;
  assign mem_enable_o = (state == WRITEBACK) || (state == ALLOCATE);
  assign mem_write_o  = (state == WRITEBACK);
  assign mem_data_o   = (state == WRITEBACK) ? rd_line : '0;

  always_comb begin
    mem_addr_o = '0;
    case (state)
      WRITEBACK: mem_addr_o = line_addr(rd_tag, miss_idx);
      ALLOCATE:  mem_addr_o = line_addr(miss_tag, miss_idx);
      default:   mem_addr_o = '0;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus random traffic
// scored against a flat word-memory reference and a behavioural line-occupancy model.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic         mem_ack_model;
  logic         force_ack;

  int errors = 0;
  int checks = 0;

  int           lat = 1;
  int           mem_cnt = 0;
  bit           mem_skip = 0;
  int           wb_count = 0;
  int           rd_count = 0;
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic [31:0]  rd_addr;

  logic [255:0] backing [int];
  logic [31:0]  truth   [int];
  bit           mv [16];
  bit           md [16];
  logic [22:0]  mt [16];

  assign mem_ack_i = mem_ack_model | force_ack;

  always #5 clk_i = ~clk_i;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  function automatic logic [31:0] init_word(input int wa);
    return (wa * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [255:0] mem_line(input int la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la * 8 + w);
    return l;
  endfunction

  function automatic logic [31:0] truth_word(input int wa);
    logic [255:0] l;
    if (truth.exists(wa)) return truth[wa];
    l = mem_line(wa / 8);
    return l[(wa % 8) * 32 +: 32];
  endfunction

  function automatic logic [255:0] truth_line(input int la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = truth_word(la * 8 + w);
    return l;
  endfunction

  // Memory responder: ack after lat enabled cycles, then one turnaround cycle before the next request.
  always @(negedge clk_i) begin
    mem_ack_model = 1'b0;
    if (rst_i) begin
      mem_cnt  = 0;
      mem_skip = 0;
    end else if (mem_skip) begin
      mem_skip = 0;
    end else if (mem_enable_o) begin
      mem_cnt++;
      if (mem_cnt >= lat) begin
        mem_cnt       = 0;
        mem_skip      = 1;
        mem_ack_model = 1'b1;
        if (mem_write_o) begin
          backing[int'(mem_addr_o >> 5)] = mem_data_o;
          wb_count++;
          wb_addr = mem_addr_o;
          wb_data = mem_data_o;
        end else begin
          mem_data_i = mem_line(int'(mem_addr_o >> 5));
          rd_count++;
          rd_addr = mem_addr_o;
        end
      end
    end else begin
      mem_cnt = 0;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0;
      md[i] = 0;
      mt[i] = '0;
    end
    truth.delete();
  endtask

  task automatic idle_inputs();
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    cpu_addr_i     = '0;
    cpu_data_i     = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    clear_model();
  endtask

  // One CPU access: predicts stall length, write-back and refill traffic, and load data.
  task automatic access(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wdata, input string name);
    int           idx;
    logic [22:0]  tag;
    bit           hit;
    bit           exp_wb;
    int           exp_stall;
    logic [31:0]  exp_wb_addr;
    logic [255:0] exp_wb_line;
    logic [31:0]  exp_data;
    int           wb0;
    int           rd0;
    int           stalls;
    idx = int'(addr[8:5]);
    tag = addr[31:9];
    hit = mv[idx] && (mt[idx] == tag);
    exp_wb = !hit && md[idx];
    exp_wb_addr = {mt[idx], addr[8:5], 5'b0};
    exp_wb_line = truth_line(int'(exp_wb_addr >> 5));
    exp_stall = hit ? 0 : (exp_wb ? 2 * lat + 3 : lat + 2);
    exp_data = truth_word(int'(addr >> 2));
    wb0 = wb_count;
    rd0 = rd_count;
    @(posedge clk_i); #1;
    cpu_addr_i     = addr;
    cpu_data_i     = wdata;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    stalls = 0;
    @(negedge clk_i);
    while (cpu_stall_o && stalls < 300) begin
      stalls++;
      @(negedge clk_i);
    end
    checks++;
    if (stalls !== exp_stall) begin
      errors++;
      $display("[TB] FAIL %s stall_cycles addr=%h: got %0d expected %0d", name, addr, stalls, exp_stall);
    end
    if (rd && !wr) begin
      checks++;
      if (cpu_data_o !== exp_data) begin
        errors++;
        $display("[TB] FAIL %s load_data addr=%h: got %h expected %h", name, addr, cpu_data_o, exp_data);
      end
    end
    checks++;
    if ((wb_count - wb0) !== (exp_wb ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL %s writeback_count: got %0d expected %0d", name, wb_count - wb0, exp_wb ? 1 : 0);
    end
    if (exp_wb) begin
      checks++;
      if (wb_addr !== exp_wb_addr || wb_data !== exp_wb_line) begin
        errors++;
        $display("[TB] FAIL %s writeback_line: got addr %h data %h expected addr %h data %h",
                 name, wb_addr, wb_data, exp_wb_addr, exp_wb_line);
      end
    end
    checks++;
    if ((rd_count - rd0) !== (hit ? 0 : 1)) begin
      errors++;
      $display("[TB] FAIL %s refill_count: got %0d expected %0d", name, rd_count - rd0, hit ? 0 : 1);
    end
    if (!hit) begin
      checks++;
      if (rd_addr !== {addr[31:5], 5'b0}) begin
        errors++;
        $display("[TB] FAIL %s refill_addr: got %h expected %h", name, rd_addr, {addr[31:5], 5'b0});
      end
    end
    @(posedge clk_i); #1;
    idle_inputs();
    mv[idx] = 1;
    mt[idx] = tag;
    if (!hit) md[idx] = 0;
    if (wr) begin
      md[idx] = 1;
      truth[int'(addr >> 2)] = wdata;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    force_ack = 1'b0;
    mem_data_i = '0;
    idle_inputs();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({cpu_stall_o, mem_enable_o, mem_write_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got stall/en/wr %b expected 000", {cpu_stall_o, mem_enable_o, mem_write_o});
    end
    checks++;
    if (cpu_data_o !== 32'h0 || mem_addr_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_addr_data: got cpu_data %h mem_addr %h expected 0 0", cpu_data_o, mem_addr_o);
    end
    checks++;
    if (mem_data_o !== 256'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem_data: got %h expected 0", mem_data_o);
    end
    #1 rst_i = 1'b0;
    clear_model();
  endtask

  task automatic test_cold_read();
    logic [255:0] l;
    l = mem_line(2);
    l[31:0] = 32'hDEADBEEF;
    backing[2] = l;
    lat = 4;
    access(32'h0000_0040, 1, 0, 32'h0, "cold_read");
    access(32'h0000_0040, 1, 0, 32'h0, "repeat_read_hit");
  endtask

  task automatic test_write_hit();
    access(32'h0000_0044, 0, 1, 32'h11223344, "write_hit");
    access(32'h0000_0044, 1, 0, 32'h0, "read_after_write");
  endtask

  task automatic test_conflict_evict();
    lat = 3;
    access(32'h0000_0240, 1, 0, 32'h0, "dirty_evict_read");
    checks++;
    if (wb_data[63:32] !== 32'h11223344) begin
      errors++;
      $display("[TB] FAIL evicted_word1: got %h expected 11223344", wb_data[63:32]);
    end
  endtask

  task automatic test_write_miss();
    lat = 2;
    access(32'h0000_0080, 0, 1, 32'hCAFEF00D, "write_miss_clean");
    access(32'h0000_0080, 1, 0, 32'h0, "read_merged");
    access(32'h0000_0280, 1, 0, 32'h0, "evict_merged_line");
  endtask

  task automatic test_reset_mid_miss();
    int wb0;
    wb0 = wb_count;
    lat = 30;
    @(posedge clk_i); #1;
    cpu_addr_i    = 32'h0000_0080;
    cpu_MemRead_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL allocate_active: got en %b wr %b expected 1 0", mem_enable_o, mem_write_o);
    end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_drop: got en %b stall %b expected 0 0", mem_enable_o, cpu_stall_o);
    end
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    clear_model();
    checks++;
    if (wb_count !== wb0) begin
      errors++;
      $display("[TB] FAIL reset_no_write: got %0d writebacks expected %0d", wb_count, wb0);
    end
    lat = 3;
    access(32'h0000_0080, 1, 0, 32'h0, "read_after_reset");
  endtask

  task automatic test_read_write_both();
    lat = 2;
    access(32'h0000_0044, 1, 0, 32'h0, "prefetch_44");
    access(32'h0000_0044, 1, 1, 32'h55667788, "both_is_write");
    @(posedge clk_i); #1 force_ack = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cpu_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ack_ignored: got stall %b en %b expected 0 0", cpu_stall_o, mem_enable_o);
    end
    @(posedge clk_i); #1 force_ack = 1'b0;
    @(negedge clk_i);
    checks++;
    if (cpu_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_ack: got stall %b en %b expected 0 0", cpu_stall_o, mem_enable_o);
    end
    access(32'h0000_0044, 1, 0, 32'h0, "read_both_result");
    access(32'h0000_0244, 1, 0, 32'h0, "evict_both_line");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      lat = 1 + (i % 3);
      access((i % 2 == 0) ? 32'h0000_0108 : 32'h0000_0308, 0, 1, $urandom, "b2b_conflict");
    end
    access(32'h0000_0108, 1, 0, 32'h0, "b2b_final_read");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int op;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      lat = $urandom_range(1, 4);
      access(a, op != 1, op != 0, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_conflict_evict();
    test_write_miss();
    test_reset_mid_miss();
    test_read_write_both();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
